// File: rtl/layer_seq.sv
// ---------------------------------------------------------------------------
// layer_seq
//
// Multi-layer sequencer for the tiny_dnn accelerator top. The host fills a
// small descriptor table. A start pulse then walks up to NL layers. For each
// layer the sequencer optionally loads weights, then optionally loads biases,
// then executes. It steps from phase to phase on stream-completion events, so
// the host does not have to poll between phases.
//
// Stream events: src_fire_last and dst_fire_last are single-cycle flags for
// completed transfers (valid & ready & last, all in the same cycle) on the
// source and destination AXI streams. The sequencer never back-pressures
// them. A phase that waits for one of these events consumes exactly one of
// them. An event that arrives while no phase is waiting for it is discarded.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   cfg_we/addr/wdata descriptor write port (accepted in IDLE/DONE only)
//   start, n_layers   start pulse with layer count (0..NL)
//   abort             return to IDLE on the next cycle, with no done pulse
//   src_fire_last     end of a weight/bias stream (source side)
//   dst_fire_last     end of a result stream (destination side)
//   run, wwrite, bwrite, backprop, deltaw, enbias, last
//                     registered mode strobes to the accelerator top
//   geom              geometry bus {ss..kw} of the current layer
//   layer_idx         index of the current layer
//   busy              a sequence is in progress
//   done              one-cycle pulse when a sequence ends
//   err               sticky error flag (bad cfg write or start)
//   state_dbg         current FSM state, for debug and checkers
//
// Descriptor layout (bit 0 = LSB):
//   {geometry[GW-1:0], last_f, enbias_f, deltaw_f, backprop_f, bload_f, wload_f}
// ---------------------------------------------------------------------------
module layer_seq #(
    parameter int NL = 8,
    parameter int GW = 116,
    parameter int DW = GW + 6,
    localparam int AW = $clog2(NL),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    input  logic          start,
    input  logic [CW-1:0] n_layers,
    input  logic          abort,
    input  logic          src_fire_last,
    input  logic          dst_fire_last,
    output logic          run,
    output logic          wwrite,
    output logic          bwrite,
    output logic          backprop,
    output logic          deltaw,
    output logic          enbias,
    output logic          last,
    output logic [GW-1:0] geom,
    output logic [AW-1:0] layer_idx,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WLD   = 3'd2,
        S_BLD   = 3'd3,
        S_GAP   = 3'd4,
        S_RUN   = 3'd5,
        S_NEXT  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam logic [CW-1:0] NL_C  = CW'(NL);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    // Descriptor field positions
    localparam int F_WLOAD    = 0;
    localparam int F_BLOAD    = 1;
    localparam int F_BACKPROP = 2;
    localparam int F_DELTAW   = 3;
    localparam int F_ENBIAS   = 4;
    localparam int F_LAST     = 5;

    state_t        state;
    logic          fetch_ph;     // 0: address cycle, 1: data cycle
    logic [CW-1:0] n_reg;        // layer count captured at start
    logic          bload_flag;   // current layer also loads biases
    logic          last_flag;    // descriptor forces last on this layer
    logic          gap_to_run;   // GAP exits to RUN (1) or to BLD (0)
    logic [DW-1:0] rd_data;

    logic [DW-1:0] mem [NL];

    logic          idle_like;
    logic          cfg_ok;
    logic [CW-1:0] idx_next;
    logic          is_final;

    // DONE behaves like IDLE for cfg writes and for start.
    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign cfg_ok    = cfg_we && idle_like;
    assign idx_next  = {1'b0, layer_idx} + ONE_C;
    assign is_final  = (idx_next == n_reg);
    assign state_dbg = state;

    // Descriptor table: synchronous-RAM style with one cycle of read latency.
    // The table is not reset. The read address is layer_idx on every cycle,
    // and FETCH allows one cycle for that read to land in rd_data.
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            mem[cfg_addr] <= cfg_wdata;
        end
        rd_data <= mem[layer_idx];
    end

    // Main sequencer. Every output is a register. Each output is assigned
    // on the transition into the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            fetch_ph   <= 1'b0;
            n_reg      <= '0;
            bload_flag <= 1'b0;
            last_flag  <= 1'b0;
            gap_to_run <= 1'b0;
            run        <= 1'b0;
            wwrite     <= 1'b0;
            bwrite     <= 1'b0;
            backprop   <= 1'b0;
            deltaw     <= 1'b0;
            enbias     <= 1'b0;
            last       <= 1'b0;
            geom       <= '0;
            layer_idx  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;

            // A cfg write or a start that arrives mid-sequence is dropped
            // and flagged as an error.
            if (cfg_we && !idle_like) begin
                err <= 1'b1;
            end
            if (start && !idle_like) begin
                err <= 1'b1;
            end

            if (abort) begin
                // Abort takes precedence over every transition. All
                // strobes clear and no done pulse is produced.
                state      <= S_IDLE;
                fetch_ph   <= 1'b0;
                run        <= 1'b0;
                wwrite     <= 1'b0;
                bwrite     <= 1'b0;
                last       <= 1'b0;
                backprop   <= 1'b0;
                deltaw     <= 1'b0;
                enbias     <= 1'b0;
                geom       <= '0;
                layer_idx  <= '0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        state <= S_IDLE;
                        if (start) begin
                            if (n_layers == '0) begin
                                // Empty sequence: done pulse, no strobes.
                                state <= S_DONE;
                                done  <= 1'b1;
                                err   <= 1'b0;
                            end else if (n_layers > NL_C) begin
                                err <= 1'b1;
                            end else begin
                                state     <= S_FETCH;
                                fetch_ph  <= 1'b0;
                                layer_idx <= '0;
                                n_reg     <= n_layers;
                                busy      <= 1'b1;
                                err       <= 1'b0;
                            end
                        end
                    end

                    S_FETCH: begin
                        if (!fetch_ph) begin
                            fetch_ph <= 1'b1;
                        end else begin
                            fetch_ph   <= 1'b0;
                            geom       <= rd_data[DW-1:6];
                            backprop   <= rd_data[F_BACKPROP];
                            deltaw     <= rd_data[F_DELTAW];
                            enbias     <= rd_data[F_ENBIAS];
                            last_flag  <= rd_data[F_LAST];
                            bload_flag <= rd_data[F_BLOAD];
                            run        <= 1'b1;
                            if (rd_data[F_WLOAD]) begin
                                state  <= S_WLD;
                                wwrite <= 1'b1;
                            end else if (rd_data[F_BLOAD]) begin
                                state  <= S_BLD;
                                bwrite <= 1'b1;
                            end else begin
                                state <= S_RUN;
                                last  <= rd_data[F_LAST] || is_final;
                            end
                        end
                    end

                    S_WLD: begin
                        if (src_fire_last) begin
                            state      <= S_GAP;
                            run        <= 1'b0;
                            wwrite     <= 1'b0;
                            gap_to_run <= !bload_flag;
                        end
                    end

                    S_BLD: begin
                        if (src_fire_last) begin
                            state      <= S_GAP;
                            run        <= 1'b0;
                            bwrite     <= 1'b0;
                            gap_to_run <= 1'b1;
                        end
                    end

                    // One idle cycle with run low, so the downstream
                    // controls restart their counters between phases.
                    S_GAP: begin
                        run <= 1'b1;
                        if (gap_to_run) begin
                            state <= S_RUN;
                            last  <= last_flag || is_final;
                        end else begin
                            state  <= S_BLD;
                            bwrite <= 1'b1;
                        end
                    end

                    S_RUN: begin
                        if (dst_fire_last) begin
                            state <= S_NEXT;
                            run   <= 1'b0;
                            last  <= 1'b0;
                        end
                    end

                    S_NEXT: begin
                        if (is_final) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            geom      <= '0;
                            backprop  <= 1'b0;
                            deltaw    <= 1'b0;
                            enbias    <= 1'b0;
                            layer_idx <= '0;
                        end else begin
                            state     <= S_FETCH;
                            fetch_ph  <= 1'b0;
                            layer_idx <= layer_idx + 1'b1;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layer_seq.sv
// ---------------------------------------------------------------------------
// tb_layer_seq: directed vectors for layer_seq. It uses cycle tables for the
// main two-layer sequence and for the start error cases, plus hand-written
// sequences for cfg writes while busy, start while busy, and abort.
// ---------------------------------------------------------------------------
module tb_layer_seq;

  localparam int NL = 8;
  localparam int GW = 116;
  localparam int DW = GW + 6;
  localparam int AW = 3;
  localparam int CW = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_WLD = 3'd2, S_BLD = 3'd3,
                         S_GAP = 3'd4, S_RUN = 3'd5, S_NEXT = 3'd6, S_DONE = 3'd7;

  localparam logic [GW-1:0] G0 = 116'hA_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
  localparam logic [GW-1:0] G1 = 116'h3_C3C3_C3C3_C3C3_C3C3_C3C3_C3C3_C3C3;
  localparam logic [GW-1:0] GZ = '0;
  // desc0: wload + bload + enbias; desc1: backprop + deltaw + last_f, no loads
  localparam logic [DW-1:0] D0   = {G0, 6'b010011};
  localparam logic [DW-1:0] D1   = {G1, 6'b101100};
  localparam logic [DW-1:0] DBAD = {G1, 6'b000000};

  logic          clk;
  logic          rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic          start;
  logic [CW-1:0] n_layers;
  logic          abort;
  logic          src_fire_last;
  logic          dst_fire_last;
  logic          run, wwrite, bwrite, backprop, deltaw, enbias, last;
  logic [GW-1:0] geom;
  logic [AW-1:0] layer_idx;
  logic          busy, done, err;
  logic [2:0]    state_dbg;

  int checks = 0;
  int failures = 0;

  layer_seq #(.NL(NL), .GW(GW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .n_layers(n_layers), .abort(abort),
    .src_fire_last(src_fire_last), .dst_fire_last(dst_fire_last),
    .run(run), .wwrite(wwrite), .bwrite(bwrite), .backprop(backprop),
    .deltaw(deltaw), .enbias(enbias), .last(last),
    .geom(geom), .layer_idx(layer_idx), .busy(busy), .done(done),
    .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: time limit reached, required end of test");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // ---------------- vector record ----------------
  // o = {run, wwrite, bwrite, last, busy, done, err}; fl = {backprop, deltaw, enbias}
  typedef struct {
    logic          start;
    logic [CW-1:0] n;
    logic          src;
    logic          dst;
    logic          ab;
    logic [6:0]    o;
    logic [AW-1:0] idx;
    logic [2:0]    st;
    logic [2:0]    fl;
    logic [GW-1:0] g;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic [CW-1:0] n, input logic sr,
                              input logic ds, input logic ab, input logic [6:0] o,
                              input logic [AW-1:0] idx, input logic [2:0] st,
                              input logic [2:0] fl, input logic [GW-1:0] g);
    vec_t v;
    v.start = s; v.n = n; v.src = sr; v.dst = ds; v.ab = ab;
    v.o = o; v.idx = idx; v.st = st; v.fl = fl; v.g = g;
    return v;
  endfunction

  function automatic logic [15:0] outs();
    return {run, wwrite, bwrite, last, busy, done, err, layer_idx, state_dbg,
            backprop, deltaw, enbias};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [CW-1:0] n, input logic sr,
                       input logic ds, input logic ab);
    start = s; n_layers = n; src_fire_last = sr; dst_fire_last = ds; abort = ab;
    tick();
    start = 1'b0; src_fire_last = 1'b0; dst_fire_last = 1'b0; abort = 1'b0;
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; n_layers = vecs[i].n;
      src_fire_last = vecs[i].src; dst_fire_last = vecs[i].dst; abort = vecs[i].ab;
      tick();
      chk($sformatf("%s_row%0d_outs", tag, i), 128'(outs()),
          128'({vecs[i].o, vecs[i].idx, vecs[i].st, vecs[i].fl}));
      chk($sformatf("%s_row%0d_geom", tag, i), 128'(geom), 128'(vecs[i].g));
    end
    start = 1'b0; src_fire_last = 1'b0; dst_fire_last = 1'b0; abort = 1'b0;
  endtask

  task automatic load_main_table();
    vecs.delete();
    vecs.push_back(mk(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 7'b0000100, 3'd0, S_FETCH, 3'b000, GZ));
    vecs.push_back(mk(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 7'b0000100, 3'd0, S_FETCH, 3'b000, GZ));
    vecs.push_back(mk(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 7'b1100100, 3'd0, S_WLD,   3'b001, G0));
    vecs.push_back(mk(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 7'b1100100, 3'd0, S_WLD,   3'b001, G0));
    vecs.push_back(mk(1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 7'b0000100, 3'd0, S_GAP,   3'b001, G0));
    vecs.push_back(mk(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 7'b1010100, 3'd0, S_BLD,   3'b001, G0));
    vecs.push_back(mk(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 7'b1010100, 3'd0, S_BLD,   3'b001, G0));
    vecs.push_back(mk(1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 7'b0000100, 3'd0, S_GAP,   3'b001, G0));
    vecs.push_back(mk(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 7'b1000100, 3'd0, S_RUN,   3'b001, G0));
    vecs.push_back(mk(1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 7'b1000100, 3'd0, S_RUN,   3'b001, G0));
    vecs.push_back(mk(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 7'b0000100, 3'd0, S_NEXT,  3'b001, G0));
    vecs.push_back(mk(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 7'b0000100, 3'd1, S_FETCH, 3'b001, G0));
    vecs.push_back(mk(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 7'b0000100, 3'd1, S_FETCH, 3'b001, G0));
    vecs.push_back(mk(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 7'b1001100, 3'd1, S_RUN,   3'b110, G1));
    vecs.push_back(mk(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 7'b0000100, 3'd1, S_NEXT,  3'b110, G1));
    vecs.push_back(mk(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 7'b0000010, 3'd0, S_DONE,  3'b000, GZ));
    vecs.push_back(mk(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 7'b0000000, 3'd0, S_IDLE,  3'b000, GZ));
  endtask

  // ---------------- strobe invariants ----------------
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((wwrite && bwrite) || ((wwrite || bwrite) && !run)) begin
        failures++;
        $display("FAIL strobe_excl: run=%0b wwrite=%0b bwrite=%0b, required exclusive and under run",
                 run, wwrite, bwrite);
      end
    end
  end

  // ---------------- main test ----------------
  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; n_layers = '0; abort = 1'b0;
    src_fire_last = 1'b0; dst_fire_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 128'(outs()), 128'(16'h0000));
    chk("reset_geom", 128'(geom), 128'(GZ));
    rst = 1'b0;

    cfg_write(3'd0, D0);
    cfg_write(3'd1, D1);
    chk("cfg_idle_outs", 128'(outs()), 128'(16'h0000));

    // Two-layer sequence, with stray events during WLD and RUN
    load_main_table();
    run_vecs("main");

    // Start error cases: n_layers > NL, then an empty sequence clears err
    vecs.delete();
    vecs.push_back(mk(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 7'b0000001, 3'd0, S_IDLE, 3'b000, GZ));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 7'b0000001, 3'd0, S_IDLE, 3'b000, GZ));
    vecs.push_back(mk(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 7'b0000010, 3'd0, S_DONE, 3'b000, GZ));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 7'b0000000, 3'd0, S_IDLE, 3'b000, GZ));
    run_vecs("nerr");

    // cfg write and start while busy: both dropped, err sticky
    drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    chk("busy_fetch", 128'(outs()), 128'({7'b0000100, 3'd0, S_FETCH, 3'b000}));
    tick();
    tick();
    chk("busy_wld", 128'(outs()), 128'({7'b1100100, 3'd0, S_WLD, 3'b001}));
    cfg_write(3'd0, DBAD);
    chk("cfg_in_wld_err", 128'(outs()), 128'({7'b1100101, 3'd0, S_WLD, 3'b001}));
    drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    chk("start_in_wld", 128'(outs()), 128'({7'b1100101, 3'd0, S_WLD, 3'b001}));
    drive(1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    chk("busy_gap1", 128'(outs()), 128'({7'b0000101, 3'd0, S_GAP, 3'b001}));
    tick();
    chk("busy_bld", 128'(outs()), 128'({7'b1010101, 3'd0, S_BLD, 3'b001}));
    drive(1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    tick();
    chk("busy_run_last", 128'(outs()), 128'({7'b1001101, 3'd0, S_RUN, 3'b001}));
    drive(1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    chk("busy_next", 128'(outs()), 128'({7'b0000101, 3'd0, S_NEXT, 3'b001}));
    tick();
    chk("busy_done", 128'(outs()), 128'({7'b0000011, 3'd0, S_DONE, 3'b000}));
    tick();
    chk("err_sticky_idle", 128'(outs()), 128'({7'b0000001, 3'd0, S_IDLE, 3'b000}));

    // Table readback through a new run; err clears on the accepted start; abort in RUN
    drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    chk("restart_err_clr", 128'(outs()), 128'({7'b0000100, 3'd0, S_FETCH, 3'b000}));
    tick();
    tick();
    chk("readback_geom", 128'(geom), 128'(G0));
    chk("readback_wld", 128'(outs()), 128'({7'b1100100, 3'd0, S_WLD, 3'b001}));
    drive(1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("abort_run_c1", 128'(outs()), 128'({7'b1001100, 3'd0, S_RUN, 3'b001}));
    tick();
    tick();
    chk("abort_run_c3", 128'(outs()), 128'({7'b1001100, 3'd0, S_RUN, 3'b001}));
    drive(1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
    chk("abort_outs", 128'(outs()), 128'(16'h0000));
    chk("abort_geom", 128'(geom), 128'(GZ));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort_quiet%0d", i), 128'(outs()), 128'(16'h0000));
    end

    // A full sequence after the abort
    load_main_table();
    run_vecs("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
